// File: rtl/puzzle_sequencer_if.sv
// Sequencer-side bus: run control, instruction fetch and datapath handshake.
// The sequencer is the master. The environment (imem, datapath, host) is the slave.
interface puzzle_sequencer_if;
   logic        start;
   logic        abort;
   logic [15:0] op;
   logic        dp_ack;
   logic        dp_flag;
   logic [7:0]  pc;
   logic        dp_go;
   logic [15:0] dp_op;
   logic        busy;
   logic        done;
   logic        timeout;
   logic [15:0] instr_count;

   modport master (
      input  start, abort, op, dp_ack, dp_flag,
      output pc, dp_go, dp_op, busy, done, timeout, instr_count
   );

   modport slave (
      output start, abort, op, dp_ack, dp_flag,
      input  pc, dp_go, dp_op, busy, done, timeout, instr_count
   );
endinterface

// File: rtl/puzzle_sequencer.sv
// Program sequencer for the 8-puzzle solver core.
// It fetches from imem at pc and resolves JMP/JNZ locally.
// It issues all other opcodes to the datapath and waits for dp_ack.
// A run ends in DONE when FIN_PC is fetched, or in TOUT when the retire budget runs out.
module puzzle_sequencer #(
   parameter logic [7:0]  START_PC  = 8'd0,
   parameter logic [7:0]  FIN_PC    = 8'd199,
   parameter logic [3:0]  OP_JMP    = 4'hE,
   parameter logic [3:0]  OP_JNZ    = 4'hF,
   parameter logic [15:0] MAX_INSTR = 16'hFFFF
) (
   input  logic               clk,
   input  logic               rst_n,
   puzzle_sequencer_if.master bus
);

   typedef enum logic [2:0] {IDLE, FETCH, EXEC, WAIT, DONE, TOUT} state_t;

   state_t      state, state_nxt;
   logic [7:0]  pc_q;
   logic [15:0] ir;
   logic        flag_q;
   logic [15:0] count_q;
   logic        done_q;
   logic        tout_q;

   logic        run_start, ir_load, pc_load, flag_load, retire, hit_fin, dp_go_c;
   logic [7:0]  pc_nxt;
   logic [15:0] count_inc;
   logic        budget_hit;

   assign count_inc  = count_q + 16'd1;
   assign budget_hit = (count_inc == MAX_INSTR);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop samples pre-edge values.
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and per-cycle control decode. Abort overrides everything.
   always_comb begin
      // NOTE: every output gets a default first, so no path leaves a latch behind.
      state_nxt = state;
      dp_go_c   = 1'b0;
      run_start = 1'b0;
      ir_load   = 1'b0;
      pc_load   = 1'b0;
      pc_nxt    = pc_q;
      flag_load = 1'b0;
      retire    = 1'b0;
      hit_fin   = 1'b0;
      if (bus.abort) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE, DONE, TOUT: begin
               if (bus.start) begin
                  run_start = 1'b1;
                  state_nxt = FETCH;
               end
            end
            FETCH: begin
               if (pc_q == FIN_PC) begin
                  hit_fin   = 1'b1;
                  state_nxt = DONE;
               end else begin
                  ir_load   = 1'b1;
                  state_nxt = EXEC;
               end
            end
            EXEC: begin
               if (ir[15:12] == OP_JMP) begin
                  pc_load = 1'b1;
                  pc_nxt  = ir[7:0];
                  retire  = 1'b1;
               end else if (ir[15:12] == OP_JNZ) begin
                  pc_load = 1'b1;
                  pc_nxt  = flag_q ? ir[7:0] : pc_q + 8'd1;
                  retire  = 1'b1;
               end else begin
                  dp_go_c   = 1'b1;
                  state_nxt = WAIT;
               end
            end
            WAIT: begin
               if (bus.dp_ack) begin
                  flag_load = 1'b1;
                  pc_load   = 1'b1;
                  pc_nxt    = pc_q + 8'd1;
                  retire    = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
         // Every retire lands in FETCH unless this retire exhausts the budget.
         if (retire) state_nxt = budget_hit ? TOUT : FETCH;
      end
   end

   // Architectural registers: pc, ir, flag, retire counter and sticky status.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= START_PC;
         ir      <= 16'h0000;
         flag_q  <= 1'b0;
         count_q <= 16'h0000;
         done_q  <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         if (run_start) begin
            pc_q    <= START_PC;
            flag_q  <= 1'b0;
            count_q <= 16'h0000;
            done_q  <= 1'b0;
            tout_q  <= 1'b0;
         end
         if (ir_load)   ir     <= bus.op;
         if (pc_load)   pc_q   <= pc_nxt;
         if (flag_load) flag_q <= bus.dp_flag;
         if (hit_fin)   done_q <= 1'b1;
         if (retire) begin
            count_q <= count_inc;
            if (budget_hit) tout_q <= 1'b1;
         end
      end
   end

   assign bus.pc          = pc_q;
   assign bus.dp_go       = dp_go_c;
   assign bus.dp_op       = ir;
   assign bus.busy        = (state == FETCH) || (state == EXEC) || (state == WAIT);
   assign bus.done        = done_q;
   assign bus.timeout     = tout_q;
   assign bus.instr_count = count_q;

endmodule

// File: tb/tb_puzzle_sequencer.sv
// Directed bench for puzzle_sequencer.
// dut1 uses the default budget and runs one chained program through all branch and datapath cases.
// dut2 uses a budget of 3 to exercise the timeout.
module tb_puzzle_sequencer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   errors = 0;

   logic [15:0] rom1 [256];
   logic [15:0] rom2 [256];

   puzzle_sequencer_if bus1 ();
   puzzle_sequencer_if bus2 ();

   assign bus1.op = rom1[bus1.pc];
   assign bus2.op = rom2[bus2.pc];

   puzzle_sequencer dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
   puzzle_sequencer #(.MAX_INSTR(16'd3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

   always #5 clk = ~clk;

   // Hard stop in case a bounded wait is ever mis-sized.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      step();
      checks++; if (bus1.pc !== 8'd0) begin errors++; $display("FAIL reset_pc: got %0d expected 0", bus1.pc); end
      checks++; if (bus1.busy !== 1'b0 || bus1.dp_go !== 1'b0) begin errors++; $display("FAIL reset_busy_go: got busy=%b go=%b expected 0/0", bus1.busy, bus1.dp_go); end
      checks++; if (bus1.done !== 1'b0 || bus1.timeout !== 1'b0) begin errors++; $display("FAIL reset_status: got done=%b tout=%b expected 0/0", bus1.done, bus1.timeout); end
      checks++; if (bus1.instr_count !== 16'd0 || bus1.dp_op !== 16'd0) begin errors++; $display("FAIL reset_count_ir: got cnt=%0d ir=%h expected 0/0000", bus1.instr_count, bus1.dp_op); end
      checks++; if (bus2.busy !== 1'b0 || bus2.timeout !== 1'b0) begin errors++; $display("FAIL reset_dut2: got busy=%b tout=%b expected 0/0", bus2.busy, bus2.timeout); end
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_timeout();
      bus2.start = 1'b1;
      step();
      bus2.start = 1'b0;
      checks++; if (bus2.busy !== 1'b1) begin errors++; $display("FAIL tout_busy: got %b expected 1", bus2.busy); end
      repeat (4) step();
      checks++; if (bus2.instr_count !== 16'd2 || bus2.timeout !== 1'b0) begin errors++; $display("FAIL tout_mid: got cnt=%0d tout=%b expected 2/0", bus2.instr_count, bus2.timeout); end
      repeat (2) step();
      checks++; if (bus2.timeout !== 1'b1 || bus2.busy !== 1'b0) begin errors++; $display("FAIL tout_hit: got tout=%b busy=%b expected 1/0", bus2.timeout, bus2.busy); end
      checks++; if (bus2.instr_count !== 16'd3 || bus2.done !== 1'b0) begin errors++; $display("FAIL tout_count: got cnt=%0d done=%b expected 3/0", bus2.instr_count, bus2.done); end
      step();
      checks++; if (bus2.timeout !== 1'b1 || bus2.instr_count !== 16'd3) begin errors++; $display("FAIL tout_sticky: got tout=%b cnt=%0d expected 1/3", bus2.timeout, bus2.instr_count); end
   endtask

   task automatic test_jmp();
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      checks++; if (bus1.busy !== 1'b1 || bus1.pc !== 8'd0) begin errors++; $display("FAIL jmp_start: got busy=%b pc=%0d expected 1/0", bus1.busy, bus1.pc); end
      step();
      checks++; if (bus1.dp_go !== 1'b0) begin errors++; $display("FAIL jmp_no_go: got %b expected 0", bus1.dp_go); end
      step();
      checks++; if (bus1.pc !== 8'd5 || bus1.instr_count !== 16'd1) begin errors++; $display("FAIL jmp_target: got pc=%0d cnt=%0d expected 5/1", bus1.pc, bus1.instr_count); end
   endtask

   task automatic test_dp_op();
      for (int i = 0; i < 10; i++) begin
         if (bus1.dp_go) break;
         step();
      end
      checks++; if (bus1.dp_go !== 1'b1) begin errors++; $display("FAIL dp_go_seen: got %b expected 1 within budget", bus1.dp_go); end
      checks++; if (bus1.dp_op !== 16'h1234 || bus1.pc !== 8'd3) begin errors++; $display("FAIL dp_issue: got op=%h pc=%0d expected 1234/3", bus1.dp_op, bus1.pc); end
      for (int i = 1; i <= 4; i++) begin
         step();
         checks++; if (bus1.dp_go !== 1'b0 || bus1.dp_op !== 16'h1234 || bus1.busy !== 1'b1) begin errors++; $display("FAIL dp_hold%0d: got go=%b op=%h busy=%b expected 0/1234/1", i, bus1.dp_go, bus1.dp_op, bus1.busy); end
         if (i == 4) begin
            bus1.dp_ack  = 1'b1;
            bus1.dp_flag = 1'b1;
         end
      end
      step();
      bus1.dp_ack = 1'b0;
      checks++; if (bus1.pc !== 8'd4 || bus1.instr_count !== 16'd3) begin errors++; $display("FAIL dp_retire: got pc=%0d cnt=%0d expected 4/3", bus1.pc, bus1.instr_count); end
      repeat (2) step();
      checks++; if (bus1.pc !== 8'd197 || bus1.instr_count !== 16'd4) begin errors++; $display("FAIL jnz_taken: got pc=%0d cnt=%0d expected 197/4", bus1.pc, bus1.instr_count); end
   endtask

   task automatic test_jnz_not_taken();
      for (int i = 0; i < 10; i++) begin
         if (bus1.dp_go) break;
         step();
      end
      checks++; if (bus1.dp_go !== 1'b1 || bus1.dp_op !== 16'h2000) begin errors++; $display("FAIL nt_issue: got go=%b op=%h expected 1/2000", bus1.dp_go, bus1.dp_op); end
      step();
      bus1.dp_ack  = 1'b1;
      bus1.dp_flag = 1'b0;
      step();
      bus1.dp_ack = 1'b0;
      checks++; if (bus1.pc !== 8'd198) begin errors++; $display("FAIL nt_ack_pc: got %0d expected 198", bus1.pc); end
      repeat (2) step();
      checks++; if (bus1.pc !== 8'd7) begin errors++; $display("FAIL nt_jmp7: got %0d expected 7", bus1.pc); end
      repeat (2) step();
      checks++; if (bus1.pc !== 8'd8 || bus1.instr_count !== 16'd7) begin errors++; $display("FAIL jnz_not_taken: got pc=%0d cnt=%0d expected 8/7", bus1.pc, bus1.instr_count); end
   endtask

   task automatic test_fin();
      repeat (2) step();
      checks++; if (bus1.pc !== 8'd199 || bus1.instr_count !== 16'd8 || bus1.done !== 1'b0) begin errors++; $display("FAIL fin_pc: got pc=%0d cnt=%0d done=%b expected 199/8/0", bus1.pc, bus1.instr_count, bus1.done); end
      step();
      checks++; if (bus1.done !== 1'b1 || bus1.busy !== 1'b0 || bus1.timeout !== 1'b0) begin errors++; $display("FAIL fin_done: got done=%b busy=%b tout=%b expected 1/0/0", bus1.done, bus1.busy, bus1.timeout); end
      step();
      checks++; if (bus1.done !== 1'b1 || bus1.instr_count !== 16'd8) begin errors++; $display("FAIL fin_sticky: got done=%b cnt=%0d expected 1/8", bus1.done, bus1.instr_count); end
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      checks++; if (bus1.done !== 1'b0 || bus1.pc !== 8'd0 || bus1.instr_count !== 16'd0 || bus1.busy !== 1'b1) begin errors++; $display("FAIL fin_restart: got done=%b pc=%0d cnt=%0d busy=%b expected 0/0/0/1", bus1.done, bus1.pc, bus1.instr_count, bus1.busy); end
   endtask

   task automatic test_abort();
      for (int i = 0; i < 10; i++) begin
         if (bus1.dp_go) break;
         step();
      end
      checks++; if (bus1.dp_go !== 1'b1 || bus1.pc !== 8'd3) begin errors++; $display("FAIL abort_issue: got go=%b pc=%0d expected 1/3", bus1.dp_go, bus1.pc); end
      step();
      bus1.abort = 1'b1;
      bus1.start = 1'b1;
      step();
      bus1.abort = 1'b0;
      bus1.start = 1'b0;
      checks++; if (bus1.busy !== 1'b0 || bus1.dp_go !== 1'b0 || bus1.pc !== 8'd3 || bus1.instr_count !== 16'd2) begin errors++; $display("FAIL abort_idle: got busy=%b go=%b pc=%0d cnt=%0d expected 0/0/3/2", bus1.busy, bus1.dp_go, bus1.pc, bus1.instr_count); end
      bus1.dp_ack  = 1'b1;
      bus1.dp_flag = 1'b1;
      step();
      bus1.dp_ack = 1'b0;
      step();
      checks++; if (bus1.busy !== 1'b0 || bus1.pc !== 8'd3 || bus1.instr_count !== 16'd2 || bus1.done !== 1'b0) begin errors++; $display("FAIL abort_late_ack: got busy=%b pc=%0d cnt=%0d done=%b expected 0/3/2/0", bus1.busy, bus1.pc, bus1.instr_count, bus1.done); end
   endtask

   task automatic test_async_reset();
      bus1.start = 1'b1;
      step();
      bus1.start = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (bus1.dp_go) break;
         step();
      end
      checks++; if (bus1.dp_go !== 1'b1 || bus1.pc !== 8'd3 || bus1.instr_count !== 16'd2) begin errors++; $display("FAIL arst_pre: got go=%b pc=%0d cnt=%0d expected 1/3/2", bus1.dp_go, bus1.pc, bus1.instr_count); end
      #1;
      rst_n = 1'b0;
      #1;
      checks++; if (bus1.pc !== 8'd0 || bus1.instr_count !== 16'd0 || bus1.dp_op !== 16'd0) begin errors++; $display("FAIL arst_regs: got pc=%0d cnt=%0d ir=%h expected 0/0/0000", bus1.pc, bus1.instr_count, bus1.dp_op); end
      checks++; if (bus1.dp_go !== 1'b0 || bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.timeout !== 1'b0) begin errors++; $display("FAIL arst_ctrl: got go=%b busy=%b done=%b tout=%b expected 0/0/0/0", bus1.dp_go, bus1.busy, bus1.done, bus1.timeout); end
      step();
      rst_n = 1'b1;
      step();
      checks++; if (bus1.busy !== 1'b0 || bus1.pc !== 8'd0) begin errors++; $display("FAIL arst_idle: got busy=%b pc=%0d expected 0/0", bus1.busy, bus1.pc); end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         rom1[i] = 16'h0000;
         rom2[i] = 16'h0000;
      end
      rom1[0]   = 16'hE005;  // JMP 5
      rom1[5]   = 16'hE003;  // JMP 3
      rom1[3]   = 16'h1234;  // datapath op
      rom1[4]   = 16'hF0C5;  // JNZ 197
      rom1[197] = 16'h2000;  // datapath op
      rom1[198] = 16'hE007;  // JMP 7
      rom1[7]   = 16'hF016;  // JNZ 0x16
      rom1[8]   = 16'hE0C7;  // JMP 199 (FIN)
      rom2[0]   = 16'hE000;  // JMP 0 forever

      bus1.start = 1'b0; bus1.abort = 1'b0; bus1.dp_ack = 1'b0; bus1.dp_flag = 1'b0;
      bus2.start = 1'b0; bus2.abort = 1'b0; bus2.dp_ack = 1'b0; bus2.dp_flag = 1'b0;

      test_reset();
      test_timeout();
      test_jmp();
      test_dp_op();
      test_jnz_not_taken();
      test_fin();
      test_abort();
      test_async_reset();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
